doled_frame_arbiter: RTL and testbench

Shares the single `doled` LED-string driver between two frame producers (for example the pattern generator and the blur engine). Grants the driver for one whole frame at a time with round-robin fairness, then issues start frame, `STRING_SIZE` pixels and end frame through the driver's start/busy handshake. Sits between the producers and `doled`, clocked by the string clock.

---
 rtl/doled_pkg.sv | 22 ++
 rtl/doled_frame_arbiter.sv | 176 +++++++++++++++++
 tb/tb_doled_frame_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/doled_pkg.sv
// Shared definitions for the doled LED-string driver and the frame arbiter
// that feeds it.
package doled_pkg;

    localparam int DEFAULT_STRING_SIZE = 46;

    localparam logic [1:0] INPUT_TYPE_START = 2'd0;
    localparam logic [1:0] INPUT_TYPE_LED   = 2'd1;
    localparam logic [1:0] INPUT_TYPE_END   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE_START,
        ST_WAIT_ACK_START,
        ST_WAIT_PIXEL,
        ST_WAIT_ACK_PIXEL,
        ST_WAIT_IDLE_END,
        ST_WAIT_ACK_END,
        ST_WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/doled_frame_arbiter.sv
// Round-robin, frame-at-a-time arbiter that lets two producers share one doled
// driver, sequencing START / STRING_SIZE x LED / END over its start/busy handshake.
module doled_frame_arbiter
    import doled_pkg::*;
#(
    parameter int STRING_SIZE = DEFAULT_STRING_SIZE,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [1:0]  req,
    output logic [1:0]  grant,
    input  logic [23:0] pix_data0,
    input  logic [23:0] pix_data1,
    input  logic [1:0]  pix_valid,
    output logic [1:0]  pix_ack,
    output logic [7:0]  pixel_index,
    output logic        frame_done,
    output logic        ack_timeout,
    output logic [1:0]  input_type,
    output logic [7:0]  blue_out,
    output logic [7:0]  green_out,
    output logic [7:0]  red_out,
    output logic        led_start,
    input  logic        doled_busy
);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    arb_state_t        r_state, w_state;
    logic              r_owner, w_owner;
    logic              r_last_owner, w_last_owner;
    logic [TO_W-1:0]   r_to_cnt, w_to_cnt;
    logic [1:0]        r_grant, w_grant;
    logic [1:0]        r_pix_ack, w_pix_ack;
    logic [7:0]        r_pixel_index, w_pixel_index;
    logic              r_frame_done, w_frame_done;
    logic              r_ack_timeout, w_ack_timeout;
    logic [1:0]        r_input_type, w_input_type;
    logic [23:0]       r_bgr, w_bgr;
    logic              r_led_start, w_led_start;

    logic              w_winner;
    logic              w_owner_valid;
    logic [23:0]       w_owner_data;
    logic              w_to_expired;

    // A lone requester always wins; on a tie the one that did not go last wins.
    assign w_winner      = (req == 2'b10) ? 1'b1 : (req == 2'b01) ? 1'b0 : ~r_last_owner;
    assign w_owner_valid = r_owner ? pix_valid[1] : pix_valid[0];
    assign w_owner_data  = r_owner ? pix_data1 : pix_data0;
    assign w_to_expired  = (r_to_cnt == TO_W'(ACK_TIMEOUT - 1));

    always_comb begin
        // NOTE: every next-state value gets a default first so no path can infer a latch.
        w_state       = r_state;
        w_owner       = r_owner;
        w_last_owner  = r_last_owner;
        w_to_cnt      = r_to_cnt;
        w_grant       = r_grant;
        w_pix_ack     = 2'b00;
        w_pixel_index = r_pixel_index;
        w_frame_done  = 1'b0;
        w_ack_timeout = 1'b0;
        w_input_type  = r_input_type;
        w_bgr         = r_bgr;
        w_led_start   = r_led_start;

        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_owner       = w_winner;
                    w_grant       = w_winner ? 2'b10 : 2'b01;
                    w_pixel_index = 8'd0;
                    w_state       = ST_WAIT_IDLE_START;
                end
            end
            ST_WAIT_IDLE_START, ST_WAIT_IDLE_END: begin
                if (!doled_busy) begin
                    w_input_type = (r_state == ST_WAIT_IDLE_START) ? INPUT_TYPE_START
                                                                    : INPUT_TYPE_END;
                    w_led_start  = 1'b1;
                    w_to_cnt     = '0;
                    w_state      = (r_state == ST_WAIT_IDLE_START) ? ST_WAIT_ACK_START
                                                                    : ST_WAIT_ACK_END;
                end
            end
            ST_WAIT_PIXEL: begin
                if (!doled_busy && w_owner_valid) begin
                    w_bgr        = w_owner_data;
                    w_input_type = INPUT_TYPE_LED;
                    w_pix_ack    = r_owner ? 2'b10 : 2'b01;
                    w_led_start  = 1'b1;
                    w_to_cnt     = '0;
                    w_state      = ST_WAIT_ACK_PIXEL;
                end
            end
            ST_WAIT_ACK_START, ST_WAIT_ACK_PIXEL, ST_WAIT_ACK_END: begin
                if (doled_busy) begin
                    w_led_start = 1'b0;
                    if (r_state == ST_WAIT_ACK_START) begin
                        w_state = ST_WAIT_PIXEL;
                    end else if (r_state == ST_WAIT_ACK_END) begin
                        w_state = ST_WAIT_DONE;
                    end else if (r_pixel_index == 8'(STRING_SIZE - 1)) begin
                        w_state = ST_WAIT_IDLE_END;
                    end else begin
                        w_pixel_index = r_pixel_index + 8'd1;
                        w_state       = ST_WAIT_PIXEL;
                    end
                end else if (w_to_expired) begin
                    // Driver never acknowledged: abandon the frame and free the string.
                    w_led_start   = 1'b0;
                    w_ack_timeout = 1'b1;
                    w_grant       = 2'b00;
                    w_last_owner  = r_owner;
                    w_state       = ST_IDLE;
                end else begin
                    w_to_cnt = r_to_cnt + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!doled_busy) begin
                    w_frame_done = 1'b1;
                    w_last_owner = r_owner;
                    w_grant      = 2'b00;
                    w_state      = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_owner       <= 1'b0;
            r_last_owner  <= 1'b1;
            r_to_cnt      <= '0;
            r_grant       <= 2'b00;
            r_pix_ack     <= 2'b00;
            r_pixel_index <= 8'd0;
            r_frame_done  <= 1'b0;
            r_ack_timeout <= 1'b0;
            r_input_type  <= INPUT_TYPE_START;
            r_bgr         <= 24'd0;
            r_led_start   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            r_state       <= w_state;
            r_owner       <= w_owner;
            r_last_owner  <= w_last_owner;
            r_to_cnt      <= w_to_cnt;
            r_grant       <= w_grant;
            r_pix_ack     <= w_pix_ack;
            r_pixel_index <= w_pixel_index;
            r_frame_done  <= w_frame_done;
            r_ack_timeout <= w_ack_timeout;
            r_input_type  <= w_input_type;
            r_bgr         <= w_bgr;
            r_led_start   <= w_led_start;
        end
    end

    assign grant       = r_grant;
    assign pix_ack     = r_pix_ack;
    assign pixel_index = r_pixel_index;
    assign frame_done  = r_frame_done;
    assign ack_timeout = r_ack_timeout;
    assign input_type  = r_input_type;
    assign blue_out    = r_bgr[23:16];
    assign green_out   = r_bgr[15:8];
    assign red_out     = r_bgr[7:0];
    assign led_start   = r_led_start;

endmodule

// File: tb/tb_doled_frame_arbiter.sv
// Scoreboard bench for doled_frame_arbiter: stimulus pushes expected commands,
// acks and grants; a negedge monitor pops and compares as the DUT emits them.
module tb_doled_frame_arbiter;
    import doled_pkg::*;

    localparam int NPIX = 4;
    localparam int TO   = 8;

    logic        CLK;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic [23:0] pix_data0;
    logic [23:0] pix_data1;
    logic [1:0]  pix_valid;
    logic [1:0]  pix_ack;
    logic [7:0]  pixel_index;
    logic        frame_done;
    logic        ack_timeout;
    logic [1:0]  input_type;
    logic [7:0]  blue_out;
    logic [7:0]  green_out;
    logic [7:0]  red_out;
    logic        led_start;
    logic        doled_busy;

    doled_frame_arbiter #(.STRING_SIZE(NPIX), .ACK_TIMEOUT(TO)) dut (
        .CLK(CLK), .rst_n(rst_n), .req(req), .grant(grant),
        .pix_data0(pix_data0), .pix_data1(pix_data1), .pix_valid(pix_valid),
        .pix_ack(pix_ack), .pixel_index(pixel_index), .frame_done(frame_done),
        .ack_timeout(ack_timeout), .input_type(input_type), .blue_out(blue_out),
        .green_out(green_out), .red_out(red_out), .led_start(led_start),
        .doled_busy(doled_busy)
    );

    typedef struct {
        logic [1:0]  typ;
        logic [23:0] data;
    } cmd_t;

    cmd_t       cmd_q[$];
    logic [1:0] ack_q[$];
    logic [1:0] grant_q[$];
    cmd_t       mon_c;
    logic [1:0] mon_v;

    int tests_run = 0;
    int fails     = 0;
    int done_cnt  = 0;
    int to_cnt    = 0;
    int led_rises = 0;
    int ack_cnt   = 0;
    int k[2];          // pixels consumed per requester (drives its data bus)
    int e[2];          // pixels expected per requester (scoreboard side)
    int busy_mode = 0; // 0 model, 1 stuck low, 2 stuck high
    int busy_left = 0;
    logic prev_led, prev_grant_any;

    // Requester i's k-th pixel, hand-built so every pixel and requester differs.
    function automatic logic [23:0] dval(input int r, input int n);
        return {8'(8'hA0 + n), 8'(8'h40 * r + n), 8'(8'h0F ^ n)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int o, input int npix, input bit with_end);
        cmd_t c;
        grant_q.push_back(o[0] ? 2'b10 : 2'b01);
        c.typ = INPUT_TYPE_START; c.data = '0;
        cmd_q.push_back(c);
        for (int j = 0; j < npix; j++) begin
            c.typ  = INPUT_TYPE_LED;
            c.data = dval(o, e[o]);
            e[o]++;
            cmd_q.push_back(c);
            ack_q.push_back(o[0] ? 2'b10 : 2'b01);
        end
        if (with_end) begin
            c.typ = INPUT_TYPE_END; c.data = '0;
            cmd_q.push_back(c);
        end
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_grant(input int budget, input string name);
        int n = 0;
        while (grant == 2'b00 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(grant != 2'b00), 32'd1);
    endtask

    task automatic wait_k(input int idx, input int target, input int budget, input string name);
        int n = 0;
        while (k[idx] < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(name, 32'(k[idx] >= target), 32'd1);
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Requesters advance to their next pixel the cycle after each ack.
    initial begin
        forever begin
            @(negedge CLK);
            if (pix_ack[0]) k[0]++;
            if (pix_ack[1]) k[1]++;
            pix_data0 = dval(0, k[0]);
            pix_data1 = dval(1, k[1]);
        end
    end

    // Driver model: busy rises after start is seen and stays high for 4 cycles.
    initial begin
        forever begin
            @(negedge CLK);
            case (busy_mode)
                1: begin doled_busy = 1'b0; busy_left = 0; end
                2: begin doled_busy = 1'b1; busy_left = 0; end
                default: begin
                    if (busy_left > 0) begin
                        busy_left--;
                        if (busy_left == 0) doled_busy = 1'b0;
                    end else if (led_start && !doled_busy) begin
                        doled_busy = 1'b1;
                        busy_left  = 4;
                    end else begin
                        doled_busy = 1'b0;
                    end
                end
            endcase
        end
    end

    // Monitor: compares every command, ack and new grant against the queues.
    initial begin
        prev_led = 1'b0;
        prev_grant_any = 1'b0;
        forever begin
            @(negedge CLK);
            if (!rst_n) begin
                prev_led = 1'b0;
                prev_grant_any = 1'b0;
            end else begin
                if (led_start && !prev_led) begin
                    led_rises++;
                    if (cmd_q.size() == 0) begin
                        check("cmd_unexpected", 32'(input_type), 32'hFFFF_FFFF);
                    end else begin
                        mon_c = cmd_q.pop_front();
                        check("cmd_type", 32'(input_type), 32'(mon_c.typ));
                        if (mon_c.typ == INPUT_TYPE_LED)
                            check("cmd_data", 32'({blue_out, green_out, red_out}), 32'(mon_c.data));
                    end
                end
                if (pix_ack != 2'b00) begin
                    ack_cnt++;
                    if (ack_q.size() == 0) begin
                        check("ack_unexpected", 32'(pix_ack), 32'd0);
                    end else begin
                        mon_v = ack_q.pop_front();
                        check("pix_ack", 32'(pix_ack), 32'(mon_v));
                    end
                end
                if (grant != 2'b00 && !prev_grant_any) begin
                    if (grant_q.size() == 0) begin
                        check("grant_unexpected", 32'(grant), 32'd0);
                    end else begin
                        mon_v = grant_q.pop_front();
                        check("grant", 32'(grant), 32'(mon_v));
                    end
                end
                if (frame_done)  done_cnt++;
                if (ack_timeout) to_cnt++;
                prev_led       = led_start;
                prev_grant_any = (grant != 2'b00);
            end
        end
    end

    initial begin
        int base;
        int snap_led;
        int snap_ack;
        int n;
        rst_n = 1'b0; req = 2'b00; pix_valid = 2'b00; doled_busy = 1'b0;
        pix_data0 = dval(0, 0); pix_data1 = dval(1, 0);
        repeat (3) @(negedge CLK);
        check("rst_outputs", 32'({grant, pix_ack, pixel_index, frame_done, ack_timeout,
                                  input_type, led_start}), 32'd0);
        check("rst_color", 32'({blue_out, green_out, red_out}), 32'd0);
        rst_n = 1'b1;
        @(negedge CLK);

        // Single requester, req dropped mid-frame.
        pix_valid = 2'b01;
        push_frame(0, NPIX, 1'b1);
        req = 2'b01;
        @(negedge CLK);
        check("t1_grant_n1", 32'({grant, led_start}), 32'({2'b01, 1'b0}));
        @(negedge CLK);
        check("t1_start_n2", 32'({led_start, input_type}), 32'({1'b1, INPUT_TYPE_START}));
        req = 2'b00;
        wait_frames(1, 300, "t1_frame_done");
        check("t1_ack_count", 32'(ack_cnt), 32'(NPIX));
        check("t1_last_index", 32'(pixel_index), 32'(NPIX - 1));
        @(negedge CLK);
        check("t1_grant_released", 32'(grant), 32'd0);

        // Tie from reset: grants alternate 01, 10, 01.
        rst_n = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        pix_valid = 2'b11;
        push_frame(0, NPIX, 1'b1);
        push_frame(1, NPIX, 1'b1);
        push_frame(0, NPIX, 1'b1);
        req = 2'b11;
        wait_frames(3, 600, "t2_two_frames");
        wait_grant(20, "t2_third_grant");
        req = 2'b00;
        wait_frames(4, 300, "t2_third_frame");

        // Underrun after pixel 2.
        base = e[0];
        pix_valid = 2'b01;
        push_frame(0, NPIX, 1'b1);
        req = 2'b01;
        wait_k(0, base + 3, 300, "t3_reach_pixel2");
        pix_valid = 2'b00;
        req = 2'b00;
        @(negedge CLK);
        snap_led = led_rises;
        snap_ack = ack_cnt;
        repeat (20) @(negedge CLK);
        check("t3_gap_led_start", 32'(led_rises - snap_led), 32'd0);
        check("t3_gap_pix_ack", 32'(ack_cnt - snap_ack), 32'd0);
        check("t3_gap_index", 32'(pixel_index), 32'd3);
        pix_valid = 2'b01;
        wait_frames(5, 300, "t3_frame_done");

        // Ack timeout with busy stuck low.
        busy_mode = 1;
        push_frame(0, 0, 1'b0);
        req = 2'b01;
        wait_grant(20, "t4_grant");
        req = 2'b00;
        n = 0;
        while (!led_start && n < 20) begin
            @(negedge CLK);
            n++;
        end
        n = 0;
        while (led_start && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("t4_led_high_cycles", 32'(n), 32'(TO));
        check("t4_abort", 32'({ack_timeout, grant}), 32'({1'b1, 2'b00}));
        @(negedge CLK);
        check("t4_pulse_width", 32'({ack_timeout, led_start, grant}), 32'd0);
        busy_mode = 0;
        repeat (2) @(negedge CLK);

        // Reset mid-pixel, then a frame held off until the driver drains.
        base = e[0];
        push_frame(0, 1, 1'b0);
        req = 2'b01;
        wait_grant(20, "t5_grant");
        req = 2'b00;
        wait_k(0, base + 1, 300, "t5_first_pixel");
        #2;
        rst_n = 1'b0;
        busy_mode = 2;
        doled_busy = 1'b1;
        #1;
        check("t5_async_outputs", 32'({grant, pix_ack, pixel_index, frame_done, ack_timeout,
                                       input_type, led_start}), 32'd0);
        check("t5_async_color", 32'({blue_out, green_out, red_out}), 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        push_frame(0, NPIX, 1'b1);
        req = 2'b01;
        snap_led = led_rises;
        repeat (10) @(negedge CLK);
        check("t5_held_off", 32'({led_start, 8'(led_rises - snap_led)}), 32'd0);
        check("t5_granted_while_busy", 32'(grant), 32'b01);
        req = 2'b00;
        busy_mode = 0;
        wait_frames(6, 300, "t5_frame_done");

        // Non-owner pix_valid toggling throughout requester 1's frame.
        base = k[0];
        pix_valid = 2'b10;
        push_frame(1, NPIX, 1'b1);
        req = 2'b10;
        n = 0;
        while (done_cnt < 7 && n < 300) begin
            pix_valid[0] = ~pix_valid[0];
            @(negedge CLK);
            n++;
            if (grant != 2'b00) req = 2'b00;
        end
        check("t6_frame_done", 32'(done_cnt), 32'd7);
        check("t6_non_owner_untouched", 32'(k[0] - base), 32'd0);
        pix_valid = 2'b00;

        repeat (3) @(negedge CLK);
        check("end_cmd_queue", 32'(cmd_q.size()), 32'd0);
        check("end_ack_queue", 32'(ack_q.size()), 32'd0);
        check("end_grant_queue", 32'(grant_q.size()), 32'd0);
        check("end_timeouts", 32'(to_cnt), 32'd1);
        check("end_frames", 32'(done_cnt), 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
